fetch_controller: RTL

Sequences the byte-addressed, synchronous-read instruction memory: owns the program counter, issues one 32-bit word read per cycle when downstream has room, and presents fetched instructions to decode through a valid/ready handshake. It absorbs the memory's one-cycle read latency with a small buffer, so decode back-pressure never drops or duplicates an instruction. It also handles control-flow redirects, and it faults on misaligned or out-of-range fetch addresses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 56 +++++
 rtl/fetch_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch path: word geometry, FSM states, buffered fetch entries.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} entries; push/pop take effect at the clock edge, head is combinational.
// Flush empties it in one cycle and dominates push/pop; the caller guarantees no push when full.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  fetch_entry_t                     push_entry,
  input  logic                             pop,
  input  logic                             flush,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   count,
  output fetch_entry_t                     head
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  fetch_entry_t  mem [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Owns the PC, issues one word read per cycle to a 1-cycle-latency imem, delivers via valid/ready (2-cycle issue-to-output).
// Issues only when the buffer can absorb the landing word, so decode stalls never drop or duplicate; faults stick until reset.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 16,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic            inflight, inflight_nxt;
  logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
  logic [XLEN-1:0] fault_pc_nxt;

  logic            land;
  logic            pop;
  logic            push;
  logic            flush;
  logic            legal;
  logic            room;
  logic [XLEN:0]   last_byte;
  logic [CW:0]     occ_next;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    land_entry;

  assign land = inflight;
  assign pop  = out_valid && out_ready;

  // One extra bit so a fetch near the top of the address space cannot wrap into legality.
  assign last_byte = {1'b0, fetch_pc} + (XLEN+1)'(INSTR_BYTES - 1);
  assign legal     = (fetch_pc[1:0] == 2'b00) && (last_byte < (XLEN+1)'(IMEM_BYTES));

  // Occupancy after this edge, counting the word already in flight.
  assign occ_next = {1'b0, count} + (CW+1)'(land) - (CW+1)'(pop);
  assign room     = occ_next < (CW+1)'(BUF_DEPTH);

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    inflight_nxt    = 1'b0;
    inflight_pc_nxt = inflight_pc;
    fault_pc_nxt    = fault_pc;
    push            = land;
    flush           = 1'b0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          flush        = 1'b1;
          push         = 1'b0;
          fetch_pc_nxt = redirect_pc;
        end else if (!legal) begin
          state_nxt    = FAULT;
          fault_pc_nxt = fetch_pc;
        end else if (room) begin
          inflight_nxt    = 1'b1;
          inflight_pc_nxt = fetch_pc;
          fetch_pc_nxt    = fetch_pc + XLEN'(INSTR_BYTES);
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fault_pc    <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      inflight    <= inflight_nxt;
      inflight_pc <= inflight_pc_nxt;
      fault_pc    <= fault_pc_nxt;
    end
  end

  assign land_entry = '{pc: inflight_pc, instr: imem_instr};

  fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(land_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  assign imem_pc   = fetch_pc;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = (state == FAULT);

endmodule
